// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: the stall vectors, the
// divider FSM state encoding and the default exception vector.
package pipe_ctrl_pkg;

  // Stall vector bit order: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  localparam logic [31:0] ExcpVectorDef = 32'h0000_0020;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Multi-cycle divide sequencer: IDLE -> BUSY (DIV_CYCLES cycles) -> DONE (one cycle).
// An abort (cancel or pipeline flush) returns to IDLE from any state and beats a start.
module div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  output div_state_e state_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [7:0] CntLoad = 8'(DIV_CYCLES - 1);

  div_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DivIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = DivIdle;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        DivIdle: begin
          if (start_i) begin
            state_d = DivBusy;
            cnt_d   = CntLoad;
          end
        end
        DivBusy: begin
          if (cnt_q == 8'd0) begin
            state_d = DivDone;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        // DONE is a single cycle regardless of start still being held
        DivDone: state_d = DivIdle;
        default: state_d = DivIdle;
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = (state_q == DivBusy);
  assign done_o  = (state_q == DivDone);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stage stall requests, runs the divide
// sequencer, watches data-memory waits and issues the registered exception flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [31:0] EXCP_VECTOR = ExcpVectorDef,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_div_start,
  input  logic             ex_div_cancel,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             mem_excp,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             div_busy,
  output logic             div_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_div_state
);

  localparam logic [7:0] WdLast = 8'(MEM_TIMEOUT - 1);

  // Memory handshake: mem_req stays high while an access is outstanding and
  // the access completes on the cycle mem_ack is high; req & ~ack is a wait.
  logic       mem_wait, ex_wait, timeout;
  div_state_e div_state;

  logic             flush_q, flush_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             bus_err_q, bus_err_d;
  logic [7:0]       wd_q, wd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk    (clk),
    .rst_ni (rst),
    .start_i(ex_div_start),
    .abort_i(ex_div_cancel | flush_q),
    .state_o(div_state),
    .busy_o (div_busy),
    .done_o (div_done)
  );

  assign mem_wait = mem_req & ~mem_ack;
  // In DONE the EX stage must advance so ex_mem captures the HI/LO result
  assign ex_wait  = ex_div_start & (div_state != DivDone);
  assign timeout  = mem_wait & (wd_q == WdLast);

  always_comb begin
    stall = StallNone;
    if (!rst || flush_q) begin
      stall = StallNone;
    end else if (mem_wait) begin
      stall = StallMem;
    end else if (ex_wait) begin
      stall = StallEx;
    end else if (stallreq_id) begin
      stall = StallId;
    end
  end

  always_comb begin
    wd_d        = (!mem_wait || timeout) ? 8'd0 : wd_q + 8'd1;
    bus_err_d   = timeout;
    // A registered timeout and a fresh exception merge into one flush; both are ignored mid-flush
    flush_d     = (mem_excp | bus_err_q) & ~flush_q;
    new_pc_d    = flush_d ? EXCP_VECTOR : 32'd0;
    stall_cnt_d = (stall != StallNone) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q     <= 1'b0;
      new_pc_q    <= 32'd0;
      bus_err_q   <= 1'b0;
      wd_q        <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      bus_err_q   <= bus_err_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign bus_err       = bus_err_q;
  assign stall_cnt     = stall_cnt_q;
  assign dbg_div_state = div_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DIV_CYCLES=4, MEM_TIMEOUT=3, CNT_W=4.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned DivCycles  = 4;
  localparam int unsigned MemTimeout = 3;
  localparam int unsigned CntW       = 4;
  localparam logic [31:0] ExcpVec    = 32'h0000_0020;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stallreq_id, ex_div_start, ex_div_cancel;
  logic            mem_req, mem_ack, mem_excp;
  logic [5:0]      stall;
  logic            flush;
  logic [31:0]     new_pc;
  logic            div_busy, div_done, bus_err;
  logic [CntW-1:0] stall_cnt;
  logic [1:0]      dbg_div_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];
  logic req_pat[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic ack_pat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  pipe_ctrl #(
    .DIV_CYCLES (DivCycles),
    .MEM_TIMEOUT(MemTimeout),
    .EXCP_VECTOR(ExcpVec),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_div_start (ex_div_start),
    .ex_div_cancel(ex_div_cancel),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_excp     (mem_excp),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .bus_err      (bus_err),
    .stall_cnt    (stall_cnt),
    .dbg_div_state(dbg_div_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id   = 1'b0;
    ex_div_start  = 1'b0;
    ex_div_cancel = 1'b0;
    mem_req       = 1'b0;
    mem_ack       = 1'b0;
    mem_excp      = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, stall, 6'b0);
    check({tag, "_flush"}, flush, 1'b0);
    check({tag, "_newpc"}, new_pc, 32'd0);
    check({tag, "_busy"}, div_busy, 1'b0);
    check({tag, "_done"}, div_done, 1'b0);
    check({tag, "_buserr"}, bus_err, 1'b0);
    check({tag, "_cnt"}, stall_cnt, 4'd0);
    check({tag, "_state"}, dbg_div_state, DivIdle);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst = 1'b1;

    // Divide: stall in cycles 0..4, busy 1..4, done with stall released in 5
    repeat (5) exp_q.push_back(StallEx);
    exp_q.push_back(StallNone);
    cyc();
    ex_div_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      #2;
      check("div_stall", stall, exp_q.pop_front());
      check("div_busy", div_busy, (i >= 1 && i <= 4));
      check("div_done", div_done, (i == 5));
    end
    check("div_cnt", stall_cnt, 4'd5);
    cyc();
    ex_div_start = 1'b0;
    #2;
    check("div_idle", dbg_div_state, DivIdle);
    check("div_done_off", div_done, 1'b0);
    check("div_stall_off", stall, 6'b0);

    // Priority between mem, ex and id requests
    cyc();
    stallreq_id = 1'b1; ex_div_start = 1'b1; mem_req = 1'b1;
    #2;
    check("prio_mem", stall, 6'b011111);
    cyc();
    mem_req = 1'b0;
    #2;
    check("prio_ex", stall, 6'b001111);
    check("prio_ex_busy", div_busy, 1'b1);
    cyc();
    ex_div_start = 1'b0;
    #2;
    check("prio_id", stall, 6'b000111);
    cyc();
    mem_req = 1'b1; mem_ack = 1'b1;
    #2;
    check("prio_acked", stall, 6'b000111);
    cyc();
    mem_req = 1'b0; mem_ack = 1'b0; stallreq_id = 1'b0; ex_div_cancel = 1'b1;
    #2;
    check("cancel_stall", stall, 6'b0);
    check("cancel_busy_pre", div_busy, 1'b1);
    cyc();
    ex_div_cancel = 1'b0;
    #2;
    check("cancel_idle", dbg_div_state, DivIdle);
    check("cancel_nodone", div_done, 1'b0);
    cyc();
    ex_div_start = 1'b1; ex_div_cancel = 1'b1;
    #2;
    check("cxs_stall", stall, 6'b001111);
    cyc();
    ex_div_start = 1'b0; ex_div_cancel = 1'b0;
    #2;
    check("cxs_idle", dbg_div_state, DivIdle);
    check("cxs_busy", div_busy, 1'b0);

    // Watchdog timeout: bus_err in cycle 3, flush in cycle 4
    do_reset();
    cyc();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      #2;
      check("to_buserr", bus_err, (i == 3));
      check("to_flush", flush, (i == 4));
      check("to_newpc", new_pc, (i == 4) ? ExcpVec : 32'd0);
      check("to_stall", stall, (i == 4) ? 6'b0 : 6'b011111);
    end
    cyc();
    mem_req = 1'b0;
    #2;
    check("to_flush_off", flush, 1'b0);
    check("to_newpc_off", new_pc, 32'd0);
    check("to_buserr_off", bus_err, 1'b0);

    // An ack clears the watchdog so no timeout follows
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_req = req_pat[i]; mem_ack = ack_pat[i];
      #2;
      check("ack_buserr", bus_err, 1'b0);
    end
    cyc();
    mem_req = 1'b0; mem_ack = 1'b0;
    #2;
    check("ack_buserr_end", bus_err, 1'b0);
    check("ack_flush_end", flush, 1'b0);

    // Exception in the same cycle as bus_err gives a single flush
    cyc();
    mem_req = 1'b1;
    cyc();
    cyc();
    cyc();
    mem_req = 1'b0; mem_excp = 1'b1;
    #2;
    check("dual_buserr", bus_err, 1'b1);
    cyc();
    mem_excp = 1'b0;
    #2;
    check("dual_flush", flush, 1'b1);
    cyc();
    #2;
    check("dual_flush_once", flush, 1'b0);

    // Exception during BUSY aborts the divide
    do_reset();
    cyc();
    ex_div_start = 1'b1;
    cyc();
    cyc();
    mem_excp = 1'b1;
    #2;
    check("ex_busy", div_busy, 1'b1);
    cyc();
    #2;
    check("ex_flush", flush, 1'b1);
    check("ex_newpc", new_pc, ExcpVec);
    check("ex_stall", stall, 6'b0);
    cyc();
    mem_excp = 1'b0; ex_div_start = 1'b0;
    #2;
    check("ex_flush_once", flush, 1'b0);
    check("ex_newpc_off", new_pc, 32'd0);
    check("ex_idle", dbg_div_state, DivIdle);
    for (int i = 0; i < 3; i++) begin
      check("ex_nodone", div_done, 1'b0);
      cyc();
      #2;
    end

    // Asynchronous reset in the middle of a divide
    do_reset();
    cyc();
    ex_div_start = 1'b1;
    cyc();
    cyc();
    cyc();
    #2;
    check("mid_busy", div_busy, 1'b1);
    check("mid_cnt", stall_cnt, 4'd3);
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("mid_rel_idle", dbg_div_state, DivIdle);
    check("mid_rel_busy", div_busy, 1'b0);
    ex_div_start = 1'b0;

    // Stall counter wraps modulo 16
    do_reset();
    cyc();
    stallreq_id = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      if (i == 14) begin
        #2;
        check("wrap_15", stall_cnt, 4'd15);
      end
    end
    stallreq_id = 1'b0;
    #2;
    check("wrap_1", stall_cnt, 4'd1);
    check("wrap_stall", stall, 6'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
